ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised multi-cycle multiply/divide unit for the EX stage. It computes MULT/MULTU, DIV/DIVU and the accumulating MADD/MADDU/MSUB/MSUBU at one bit per cycle, and returns a double-width {HI, LO} result for the HI/LO write path. While an operation is in flight it asserts a stall request to the pipeline controller. A flush from the controller can annul the operation.

## Interface
Parameters:
- DATA_W, 32: operand width; result is 2*DATA_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start_i  in  1  request a new operation; accepted only in IDLE.
- annul_i  in  1  abort the current operation (pipeline flush).
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- opdata1_i  in  DATA_W  multiplicand / dividend.
- opdata2_i  in  DATA_W  multiplier / divisor.
- hi_i, lo_i  in  DATA_W each  accumulator value (forwarded HI/LO), sampled at accept.
- result_o  out  2*DATA_W  {HI, LO}; divide: HI = remainder, LO = quotient.
- ready_o  out  1  one-cycle pulse: result_o valid.
- divzero_o  out  1  with ready_o: divide by zero occurred.
- busy_o  out  1  operation in flight (MUL or DIV state).
- stallreq_o  out  1  combinational: (IDLE & start_i & ~annul_i) | busy_o.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i & ~annul_i accepts the operation. Operands, op_i and {hi_i, lo_i} are latched.
  - Signed ops convert operands to magnitudes and record the result signs.
  - Go to MUL for ops 000/001/1xx. Go to DIV for 010/011 with nonzero divisor.
  - For DIV/DIVU with opdata2_i == 0, go straight to DONE with result 0 and divzero flag set.
- MUL:
  - DATA_W iterations of shift-add on magnitudes, using a 2*DATA_W-bit product register and a DATA_W-bit iteration counter.
  - After the last iteration, apply the sign (two's complement) for signed ops.
  - MADD*: add the product to the latched {hi, lo}. MSUB*: subtract the product from it. Both are modulo 2^(2*DATA_W).
  - Then go to DONE.
- DIV:
  - DATA_W iterations of restoring division; the partial remainder is DATA_W+1 bits.
  - Signed fixup: quotient negated if the operand signs differ (truncation toward zero); remainder takes the dividend's sign.
  - Most-negative / -1 gives LO = most-negative (wraps) and HI = 0.
  - Then go to DONE.
- DONE: ready_o = 1 for exactly this cycle, then return to IDLE.
- result_o holds its value until the next accepted start. divzero_o is valid only while ready_o is high and is 0 otherwise.
- annul_i:
  - In MUL or DIV: the next state is IDLE, no ready_o pulse, and result_o keeps its previous value.
  - In IDLE: start_i is ignored.
  - In DONE: no effect; the pulse completes.
- start_i outside IDLE is ignored; it does not queue.
- Reset at any time: state IDLE. result_o = 0, ready_o = 0, divzero_o = 0, busy_o = 0, stallreq_o = 0 (unless start_i is high after reset releases).

## Timing
- Cycle 0: start_i accepted. stallreq_o = 1 combinationally.
- MUL/DIV cycles 1..DATA_W: busy_o = 1 and stallreq_o = 1.
- Cycle DATA_W+1: DONE. ready_o = 1, stallreq_o = 0, result valid.
- Latency is DATA_W+1 cycles from accept to ready. For DATA_W = 32, ready_o is high in cycle 33.
- Sign conversion and accumulate are folded into the last iteration cycle; no extra cycles.
- Divide by zero: ready_o and divzero_o high in cycle 1. stallreq_o is high only in cycle 0.
- A new start_i may be accepted in the cycle after DONE (cycle DATA_W+2) at the earliest. This includes the case where start_i is held high through DONE.
- annul_i in cycle k (1 ≤ k ≤ DATA_W) puts the unit in IDLE in cycle k+1, where a new start is accepted.

## Test plan
- MULT: opdata1 = 0xFFFFFFFF, opdata2 = 5, DATA_W = 32 -> cycle 33: ready_o = 1, result_o = 0xFFFFFFFF_FFFFFFFB; stallreq_o high cycles 0-32.
- DIVU 100 / 7 -> HI = 2, LO = 14. DIV 0xFFFFFFF9 (-7) / 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> HI = 0, LO = 0x80000000. DIV 5 / 0 -> cycle 1: ready_o = 1, divzero_o = 1, result_o = 0.
- MSUB with hi_i = 0, lo_i = 10, operands 3 and 4 -> result_o = 0xFFFFFFFF_FFFFFFFE. MADDU with hi_i = lo_i = 0xFFFFFFFF, operands 1 and 1 -> result_o = 0 (wrap).
- Annul and start rules:
  - MULTU started, annul_i in cycle 10 -> no ready_o; busy_o = 0 in cycle 11; result_o unchanged; a start in cycle 11 completes in cycle 44.
  - start_i pulsed in cycle 5 of a divide is ignored.
- rst asserted in cycle 20 of a DIV -> next cycle all outputs 0, state IDLE, no ready_o; a fresh DIVU 9/3 then gives HI = 0, LO = 3.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle multiply/divide/accumulate unit for the EX stage
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  divzero_o,
    output logic                  busy_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(DATA_W - 1);

    state_t              state;
    logic [DATA_W-1:0]   cnt;
    logic [DATA_W-1:0]   mreg;      // multiplicand magnitude or divisor magnitude
    logic [DATA_W-1:0]   rem;       // partial remainder between iterations
    logic [2*DATA_W-1:0] prod;      // product register; low half doubles as quotient shifter
    logic [2*DATA_W-1:0] acc;       // latched {hi, lo} for the accumulate ops
    logic [2:0]          op;
    logic                neg_q;     // product / quotient must be negated
    logic                neg_r;     // remainder must be negated (dividend sign)

    // Operand conditioning at accept: signed ops (op[0] == 0) work on magnitudes.
    logic                is_signed_in;
    logic                a_neg_in;
    logic                b_neg_in;
    logic [DATA_W-1:0]   mag_a_in;
    logic [DATA_W-1:0]   mag_b_in;
    logic                is_div_in;

    assign is_signed_in = ~op_i[0];
    assign a_neg_in     = is_signed_in & opdata1_i[DATA_W-1];
    assign b_neg_in     = is_signed_in & opdata2_i[DATA_W-1];
    assign mag_a_in     = a_neg_in ? -opdata1_i : opdata1_i;
    assign mag_b_in     = b_neg_in ? -opdata2_i : opdata2_i;
    assign is_div_in    = (op_i[2:1] == 2'b01);

    // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] mul_signed;
    logic [2*DATA_W-1:0] mul_final;

    assign mul_sum    = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, mreg};
    assign mul_next   = prod[0] ? {mul_sum, prod[DATA_W-1:1]} : {1'b0, prod[2*DATA_W-1:1]};
    assign mul_signed = neg_q ? -mul_next : mul_next;
    assign mul_final  = op[2] ? (op[1] ? acc - mul_signed : acc + mul_signed) : mul_signed;

    // Restoring-division step; the borrow of the (DATA_W+1)-bit trial subtract decides the quotient bit.
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign div_shift = {rem, prod[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, mreg};
    assign div_ge    = ~div_diff[DATA_W];
    assign rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    assign quo_next  = {prod[DATA_W-2:0], div_ge};
    assign quo_fix   = neg_q ? -quo_next : quo_next;
    assign rem_fix   = neg_r ? -rem_next : rem_next;

    assign busy_o     = (state == ST_MUL) || (state == ST_DIV);
    assign stallreq_o = ((state == ST_IDLE) && start_i && !annul_i) || busy_o;

    // Control FSM with registered result, ready and divide-by-zero outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mreg      <= '0;
            rem       <= '0;
            prod      <= '0;
            acc       <= '0;
            op        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            divzero_o <= 1'b0;
        end else begin
            ready_o   <= 1'b0;
            divzero_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i && !annul_i) begin
                        op    <= op_i;
                        acc   <= {hi_i, lo_i};
                        neg_q <= a_neg_in ^ b_neg_in;
                        neg_r <= a_neg_in;
                        cnt   <= '0;
                        rem   <= '0;
                        if (is_div_in) begin
                            mreg <= mag_b_in;
                            prod <= {{DATA_W{1'b0}}, mag_a_in};
                            if (opdata2_i == '0) begin
                                result_o  <= '0;
                                ready_o   <= 1'b1;
                                divzero_o <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_DIV;
                            end
                        end else begin
                            mreg  <= mag_a_in;
                            prod  <= {{DATA_W{1'b0}}, mag_b_in};
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        prod <= mul_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            result_o <= mul_final;
                            ready_o  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DIV: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        rem              <= rem_next;
                        prod[DATA_W-1:0] <= quo_next;
                        cnt              <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic [2:0]     op_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [W-1:0]   hi_i;
    logic [W-1:0]   lo_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           divzero_o;
    logic           busy_o;
    logic           stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .divzero_o  (divzero_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to just after the falling edge: inputs change and outputs are sampled here.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: {divzero, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub, p, acc, uq, um;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                q = sa / sb;
                m = sa % sb;
                p = {m[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                uq = ua / ub;
                um = ua % ub;
                p  = {um[31:0], uq[31:0]};
            end
            3'd4: p = acc + sa * sb;
            3'd5: p = acc + ua * ub;
            3'd6: p = acc - sa * sb;
            default: p = acc - ua * ub;
        endcase
        return {1'b0, p};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation from IDLE and check latency, stall/busy, result and pulse shape.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input string tag,
                          output logic [63:0] res);
        logic [64:0] ref_v;
        int          lat;
        int          exp_lat;
        bit          stall_bad;
        ref_v   = model(op, a, b, hi, lo);
        exp_lat = ref_v[64] ? 1 : W + 1;
        tick();
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
        #1;
        check_eq($sformatf("%s_stall_c0", tag), 64'(stallreq_o), 64'd1);
        tick();
        start_i   = 1'b0;
        lat       = 1;
        stall_bad = 1'b0;
        while (!ready_o && lat < 200) begin
            if (!stallreq_o || !busy_o) stall_bad = 1'b1;
            tick();
            lat++;
        end
        check_eq($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("%s_result", tag), result_o, ref_v[63:0]);
        check_eq($sformatf("%s_divzero", tag), 64'(divzero_o), 64'(ref_v[64]));
        check_eq($sformatf("%s_stall_done", tag), 64'(stallreq_o), 64'd0);
        check_eq($sformatf("%s_stall_busy", tag), 64'(stall_bad), 64'd0);
        res = result_o;
        tick();
        check_eq($sformatf("%s_pulse_end", tag), 64'({ready_o, divzero_o, busy_o}), 64'd0);
        check_eq($sformatf("%s_hold", tag), result_o, ref_v[63:0]);
    endtask

    initial begin
        logic [63:0] r;
        logic [64:0] ref_v;
        logic [31:0] a, b;
        bit          seen;
        int          lat;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("reset_outs", 64'({ready_o, divzero_o, busy_o, stallreq_o}), 64'd0);
        check_eq("reset_result", result_o, 64'd0);

        // Directed cases
        run_op(3'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, "mult", r);
        check_eq("mult_val", r, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, "divu", r);
        check_eq("divu_val", r, 64'h0000_0002_0000_000E);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, "div_neg", r);
        check_eq("div_neg_val", r, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, "div_ovf", r);
        check_eq("div_ovf_val", r, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'd5, 32'd0, 32'd0, 32'd0, "div_zero", r);
        check_eq("div_zero_val", r, 64'd0);
        run_op(3'd6, 32'd3, 32'd4, 32'd0, 32'd10, "msub", r);
        check_eq("msub_val", r, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(3'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu", r);
        check_eq("maddu_val", r, 64'd0);

        // Annul of a MULTU in cycle 10, restart in cycle 11
        run_op(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, "pre_annul", r);
        tick();
        start_i = 1'b1; op_i = 3'd1; opdata1_i = 32'h1234_5678; opdata2_i = 32'h9ABC_DEF0;
        tick();
        start_i = 1'b0;
        seen = ready_o;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        if (ready_o) seen = 1'b1;
        check_eq("annul_no_ready", 64'(seen), 64'd0);
        check_eq("annul_busy", 64'(busy_o), 64'd0);
        check_eq("annul_result_kept", result_o, 64'h0000_0002_0000_000E);
        a = $urandom(); b = $urandom();
        ref_v = model(3'd1, a, b, 32'd0, 32'd0);
        start_i = 1'b1; opdata1_i = a; opdata2_i = b;
        #1;
        check_eq("annul_restart_stall", 64'(stallreq_o), 64'd1);
        tick();
        start_i = 1'b0;
        lat = 1;
        while (!ready_o && lat < 200) begin tick(); lat++; end
        check_eq("annul_restart_lat", 64'(lat), 64'd33);
        check_eq("annul_restart_res", result_o, ref_v[63:0]);

        // Annul in IDLE blocks the start
        tick();
        start_i = 1'b1; annul_i = 1'b1;
        #1;
        check_eq("idle_annul_stall", 64'(stallreq_o), 64'd0);
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        check_eq("idle_annul_busy", 64'(busy_o), 64'd0);

        // Start pulsed during a divide is ignored
        a = $urandom(); b = $urandom_range(1, 1000);
        ref_v = model(3'd2, a, b, 32'd0, 32'd0);
        tick();
        start_i = 1'b1; op_i = 3'd2; opdata1_i = a; opdata2_i = b;
        tick();
        start_i = 1'b0;
        lat = 1;
        while (!ready_o && lat < 200) begin
            tick();
            lat++;
            if (lat == 5) begin start_i = 1'b1; op_i = 3'd1; opdata1_i = 32'd7; opdata2_i = 32'd9; end
            else start_i = 1'b0;
        end
        check_eq("ign_start_lat", 64'(lat), 64'd33);
        check_eq("ign_start_res", result_o, ref_v[63:0]);
        tick();
        check_eq("ign_start_idle", 64'({busy_o, ready_o}), 64'd0);

        // Start held high through DONE: next accept is the cycle after DONE
        a = $urandom(); b = $urandom();
        ref_v = model(3'd1, a, b, 32'd0, 32'd0);
        tick();
        start_i = 1'b1; op_i = 3'd1; opdata1_i = a; opdata2_i = b;
        tick();
        lat = 1;
        while (!ready_o && lat < 200) begin tick(); lat++; end
        check_eq("held_first_lat", 64'(lat), 64'd33);
        tick();
        check_eq("held_idle", 64'({busy_o, ready_o, stallreq_o}), 64'b001);
        tick();
        start_i = 1'b0;
        lat = 1;
        while (!ready_o && lat < 200) begin tick(); lat++; end
        check_eq("held_second_lat", 64'(lat), 64'd33);
        check_eq("held_second_res", result_o, ref_v[63:0]);

        // Reset in cycle 20 of a divide
        tick();
        start_i = 1'b1; op_i = 3'd2; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        tick();
        start_i = 1'b0;
        seen = ready_o;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_no_ready", 64'(seen), 64'd0);
        check_eq("rst_mid_outs", 64'({ready_o, divzero_o, busy_o, stallreq_o}), 64'd0);
        check_eq("rst_mid_result", result_o, 64'd0);
        run_op(3'd3, 32'd9, 32'd3, 32'd0, 32'd0, "post_rst", r);
        check_eq("post_rst_val", r, 64'h0000_0000_0000_0003);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom(), $urandom(),
                   $sformatf("rnd%0d", i), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
